id_decode_pipe: RTL and testbench
=================================

Name: id_decode_pipe

Overview:
- Parametrised instruction-decode pipeline stage between IF/ID and ID/EXE.
- Registers the fetched instruction and PC, and decodes opcode, func3, func7, rs1, rs2 and rd.
- Generates the format-correct sign-extended immediate (I/S/B/U/J) and per-instruction register read/write enables.
- Uses a valid/ready handshake on both sides, a one-entry skid buffer for full-throughput stalls, and a flush input for branch redirect.

Parameters:
XLEN, 32, datapath/immediate width (32 or 64; immediates sign-extended to XLEN)
ADDR_W, 32, instruction address width
REG_AW, 5, register address width
RST_PC, 0, PC value driven on pc_addr_o_IDP at reset/flush
NOP_INSTR, 32'h00000013, instruction word driven when the stage is empty (addi x0,x0,0)

Ports:
clk_i_IDP  in  1  clock, all state updates on rising edge
rst_i_IDP  in  1  synchronous reset, active-low
flush_i_IDP  in  1  discard held and skid entries this cycle
in_valid_i_IDP  in  1  IF/ID presents a valid instruction
in_ready_o_IDP  out  1  stage can accept an instruction
instr_i_IDP  in  32  instruction word
pc_addr_i_IDP  in  ADDR_W  instruction PC
out_valid_o_IDP  out  1  decoded bundle valid
out_ready_i_IDP  in  1  ID/EXE accepts bundle
instr_o_IDP  out  32  registered instruction
pc_addr_o_IDP  out  ADDR_W  registered PC
opcode_o_IDP  out  7  instr[6:0]
func3_o_IDP  out  3  instr[14:12]
func7_o_IDP  out  7  instr[31:25]
rs1_addr_o_IDP / rs2_addr_o_IDP / rd_addr_o_IDP  out  REG_AW each  instr[19:15] / [24:20] / [11:7]
rs1_en_o_IDP / rs2_en_o_IDP / rd_we_o_IDP  out  1 each  register read/write enables
imm_o_IDP  out  XLEN  sign-extended immediate
illegal_o_IDP  out  1  opcode not in RV32I base set

Behaviour:
- Reset (rst_i_IDP==0 at a rising edge) has the highest priority:
  - Outputs: out_valid=0, in_ready=1, instr_o=NOP_INSTR, pc=RST_PC. All other outputs 0.
  - Skid entry is invalidated.
- Flush (next priority): same values as reset, applied in the same cycle. An input transfer in that cycle is dropped.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1/cycle while out_ready=1.
- in_ready_o_IDP = ~skid_valid. It is a register output, with no combinational path from out_ready.
- State (main register M, skid register S):
  - EMPTY (M invalid): input transfer loads M -> FULL.
  - FULL (M valid, S empty):
    - output transfer with input transfer: reload M.
    - output transfer without input transfer: -> EMPTY.
    - no output transfer with input transfer: load S -> SKID.
  - SKID (both valid, in_ready=0): on output transfer, S moves to M -> FULL.
- Decode is combinational on the instruction being loaded. All outputs are registered; out_valid=0 outputs hold their last values.
- Immediate by opcode:
  - I (0010011, 0000011, 1100111): instr[31:20].
  - S (0100011): {[31:25],[11:7]}.
  - B (1100011): {[31],[7],[30:25],[11:8],0}.
  - U (0110111, 0010111): {[31:12],12'b0}.
  - J (1101111): {[31],[19:12],[20],[30:21],0}.
  - R/other: 0.
  - All formats sign-extended from the top bit to XLEN.
- Enables:
  - rs1_en: I, S, B, R (0110011).
  - rs2_en: S, B, R.
  - rd_we: R, I, U, J, and only when rd!=0.
- illegal_o is set for any opcode outside {R, I, S, B, U, J, 1110011, 0001111}. On illegal, all enables are 0.
- Simultaneous flush and out_ready: flush wins, and the bundle is not reported as consumed.

Test Plan:
- Reset low 2 cycles, then high -> out_valid=0, in_ready=1, instr_o=32'h00000013, pc=0.
- Send 0x00510093 (addi x1,x2,5) with pc=0x100 -> next cycle: out_valid=1, imm=5, rs1=2, rd=1, rs1_en=1, rs2_en=0, rd_we=1, pc=0x100.
- Send 0xFE312E23 (sw x3,-4(x2)), then 0x123452B7 (lui x5,0x12345), then 0xFF9FF06F (jal x0,-8), with out_ready=1:
  - sw: imm=0xFFFFFFFC, rs2_en=1, rd_we=0.
  - lui: imm=0x12345000.
  - jal: imm=0xFFFFFFF8, rd_we=0.
- Stream 4 instructions with out_ready=0 for cycles 2-3 -> in_ready drops after the skid fills. No instruction is lost or duplicated. Output order equals input order.
- Assert flush while in SKID state -> next cycle out_valid=0, in_ready=1. Neither held instruction ever appears.
- Send opcode 0x7F word -> illegal=1, all enables 0.

Source files
------------

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: registered RV32I decode stage with valid/ready handshake, one-entry skid buffer and flush
module id_decode_pipe #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter logic [ADDR_W-1:0] RST_PC = '0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk_i_IDP,
  input  logic              rst_i_IDP,
  input  logic              flush_i_IDP,
  input  logic              in_valid_i_IDP,
  output logic              in_ready_o_IDP,
  input  logic [31:0]       instr_i_IDP,
  input  logic [ADDR_W-1:0] pc_addr_i_IDP,
  output logic              out_valid_o_IDP,
  input  logic              out_ready_i_IDP,
  output logic [31:0]       instr_o_IDP,
  output logic [ADDR_W-1:0] pc_addr_o_IDP,
  output logic [6:0]        opcode_o_IDP,
  output logic [2:0]        func3_o_IDP,
  output logic [6:0]        func7_o_IDP,
  output logic [REG_AW-1:0] rs1_addr_o_IDP,
  output logic [REG_AW-1:0] rs2_addr_o_IDP,
  output logic [REG_AW-1:0] rd_addr_o_IDP,
  output logic              rs1_en_o_IDP,
  output logic              rs2_en_o_IDP,
  output logic              rd_we_o_IDP,
  output logic [XLEN-1:0]   imm_o_IDP,
  output logic              illegal_o_IDP
);
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rs1_en;
    logic              rs2_en;
    logic              rd_we;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } bundle_t;
  bundle_t m_q, m_d, dec, rst_val;
  logic m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [31:0] s_instr_q, s_instr_d, src;
  logic [ADDR_W-1:0] s_pc_q, s_pc_d, src_pc;
  logic in_xfer, out_xfer, load_m;
  logic [6:0] op;
  logic is_i, is_s, is_b, is_u, is_j, is_r, is_sys;
  always_comb begin
    in_xfer = in_valid_i_IDP & ~s_valid_q;
    out_xfer = m_valid_q & out_ready_i_IDP;
    load_m = s_valid_q ? out_xfer : in_xfer & (~m_valid_q | out_xfer);
    src = s_valid_q ? s_instr_q : instr_i_IDP;
    src_pc = s_valid_q ? s_pc_q : pc_addr_i_IDP;
    op = src[6:0];
    is_i = op == 7'h13 || op == 7'h03 || op == 7'h67;
    is_s = op == 7'h23;
    is_b = op == 7'h63;
    is_u = op == 7'h37 || op == 7'h17;
    is_j = op == 7'h6f;
    is_r = op == 7'h33;
    is_sys = op == 7'h73 || op == 7'h0f;
    dec.instr = src;
    dec.pc = src_pc;
    dec.opcode = op;
    dec.func3 = src[14:12];
    dec.func7 = src[31:25];
    dec.rs1 = REG_AW'(src[19:15]);
    dec.rs2 = REG_AW'(src[24:20]);
    dec.rd = REG_AW'(src[11:7]);
    dec.imm = is_i ? XLEN'($signed(src[31:20])) :
              is_s ? XLEN'($signed({src[31:25], src[11:7]})) :
              is_b ? XLEN'($signed({src[31], src[7], src[30:25], src[11:8], 1'b0})) :
              is_u ? XLEN'($signed({src[31:12], 12'b0})) :
              is_j ? XLEN'($signed({src[31], src[19:12], src[20], src[30:21], 1'b0})) : '0;
    dec.rs1_en = is_i | is_s | is_b | is_r;
    dec.rs2_en = is_s | is_b | is_r;
    dec.rd_we = (is_r | is_i | is_u | is_j) & (|src[11:7]);
    dec.illegal = ~(is_i | is_s | is_b | is_u | is_j | is_r | is_sys);
    rst_val = '0;
    rst_val.instr = NOP_INSTR;
    rst_val.pc = RST_PC;
  end
  always_comb begin
    m_valid_d = ~flush_i_IDP & (load_m | (m_valid_q & ~out_xfer));
    s_valid_d = ~flush_i_IDP & (s_valid_q ? ~out_xfer : in_xfer & m_valid_q & ~out_xfer);
    m_d = flush_i_IDP ? rst_val : load_m ? dec : m_q;
    s_instr_d = s_valid_q ? s_instr_q : instr_i_IDP;
    s_pc_d = s_valid_q ? s_pc_q : pc_addr_i_IDP;
  end
  always_ff @(posedge clk_i_IDP) begin
    if (!rst_i_IDP) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q <= rst_val;
      s_instr_q <= '0;
      s_pc_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q <= m_d;
      s_instr_q <= s_instr_d;
      s_pc_q <= s_pc_d;
    end
  end
  assign in_ready_o_IDP = ~s_valid_q;
  assign out_valid_o_IDP = m_valid_q;
  assign instr_o_IDP = m_q.instr;
  assign pc_addr_o_IDP = m_q.pc;
  assign opcode_o_IDP = m_q.opcode;
  assign func3_o_IDP = m_q.func3;
  assign func7_o_IDP = m_q.func7;
  assign rs1_addr_o_IDP = m_q.rs1;
  assign rs2_addr_o_IDP = m_q.rs2;
  assign rd_addr_o_IDP = m_q.rd;
  assign rs1_en_o_IDP = m_q.rs1_en;
  assign rs2_en_o_IDP = m_q.rs2_en;
  assign rd_we_o_IDP = m_q.rd_we;
  assign imm_o_IDP = m_q.imm;
  assign illegal_o_IDP = m_q.illegal;
endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed self-checking bench for id_decode_pipe
module tb_id_decode_pipe;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] instr_i = '0, instr_o, pc_i = '0, pc_o, imm;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic [4:0] rs1, rs2, rd;
  logic rs1_en, rs2_en, rd_we, illegal;
  int n_checks = 0, n_errors = 0;
  logic [31:0] vec [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
  logic [31:0] rx [$];
  logic saw_stall;
  int idx;
  logic acc;
  always #5 clk = ~clk;
  id_decode_pipe dut (
    .clk_i_IDP(clk), .rst_i_IDP(rst), .flush_i_IDP(flush),
    .in_valid_i_IDP(in_valid), .in_ready_o_IDP(in_ready),
    .instr_i_IDP(instr_i), .pc_addr_i_IDP(pc_i),
    .out_valid_o_IDP(out_valid), .out_ready_i_IDP(out_ready),
    .instr_o_IDP(instr_o), .pc_addr_o_IDP(pc_o),
    .opcode_o_IDP(opcode), .func3_o_IDP(func3), .func7_o_IDP(func7),
    .rs1_addr_o_IDP(rs1), .rs2_addr_o_IDP(rs2), .rd_addr_o_IDP(rd),
    .rs1_en_o_IDP(rs1_en), .rs2_en_o_IDP(rs2_en), .rd_we_o_IDP(rd_we),
    .imm_o_IDP(imm), .illegal_o_IDP(illegal)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] w, input logic [31:0] p);
    in_valid = 1'b1;
    instr_i = w;
    pc_i = p;
    tick();
  endtask
  task automatic chk_dec(input string tag, input logic [31:0] w, input logic [31:0] im, input logic [2:0] en);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_instr"}, instr_o, w);
    check({tag, "_imm"}, imm, im);
    check({tag, "_en"}, {rs1_en, rs2_en, rd_we}, en);
  endtask
  initial begin
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_instr", instr_o, 32'h00000013);
    check("rst_pc", pc_o, 0);
    check("rst_fields", {opcode, func3, func7, rs1, rs2, rd, rs1_en, rs2_en, rd_we, illegal}, 0);
    check("rst_imm", imm, 0);
    send(32'h00510093, 32'h100);
    chk_dec("addi", 32'h00510093, 5, 3'b101);
    check("addi_regs", {rs1, rd}, {5'd2, 5'd1});
    check("addi_pc", pc_o, 32'h100);
    check("addi_op", {opcode, func3, illegal}, {7'h13, 3'd0, 1'b0});
    send(32'hFE312E23, 32'h104);
    chk_dec("sw", 32'hFE312E23, 32'hFFFFFFFC, 3'b110);
    check("sw_regs", {rs1, rs2, func3, func7}, {5'd2, 5'd3, 3'd2, 7'h7F});
    send(32'h123452B7, 32'h108);
    chk_dec("lui", 32'h123452B7, 32'h12345000, 3'b001);
    check("lui_rd", rd, 5);
    send(32'hFF9FF06F, 32'h10C);
    chk_dec("jal", 32'hFF9FF06F, 32'hFFFFFFF8, 3'b000);
    check("jal_pc", pc_o, 32'h10C);
    send(32'hFE000EE3, 32'h110);
    chk_dec("beq", 32'hFE000EE3, 32'hFFFFFFFC, 3'b110);
    send(32'h00000073, 32'h114);
    chk_dec("ecall", 32'h00000073, 0, 3'b000);
    check("ecall_illegal", illegal, 0);
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);
    idx = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 20 && rx.size() < 4; cyc++) begin
      in_valid = idx < 4;
      instr_i = idx < 4 ? vec[idx] : 32'h0;
      pc_i = 32'h200 + 32'(idx * 4);
      out_ready = !(cyc == 2 || cyc == 3);
      if (out_valid && out_ready) rx.push_back(instr_o);
      if (!in_ready) saw_stall = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stream_count", rx.size(), 4);
    check("stream_stall", saw_stall, 1);
    for (int i = 0; i < 4; i++) check($sformatf("stream_order%0d", i), i < rx.size() ? rx[i] : 32'hx, vec[i]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(32'h00A00513, 32'h300);
    send(32'h00B00593, 32'h304);
    in_valid = 1'b0;
    check("skid_ready", in_ready, 0);
    check("skid_valid", out_valid, 1);
    flush = 1'b1;
    out_ready = 1'b1;
    send(32'h00C00613, 32'h308);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_instr", instr_o, 32'h00000013);
    check("flush_pc", pc_o, 0);
    tick();
    tick();
    tick();
    check("flush_gone", out_valid, 0);
    send(32'hFFFFFFFF, 32'h400);
    chk_dec("illegal", 32'hFFFFFFFF, 0, 3'b000);
    check("illegal_flag", illegal, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("hold_valid", out_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_valid", out_valid, 0);
    check("rst2_illegal", illegal, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
